// File: rtl/cpu_controller.sv
// cpu_controller
//   Multi-cycle control FSM (FETCH -> DECODE -> EXEC -> MEM -> WB) for the
//   single-issue core. Decodes the instruction register contents and drives
//   the PC / immediate / ALU-src2 / writeback mux selects and the register
//   file, instruction register, PC and data-memory enables.
// Ports
//   clk, rst           : system clock, synchronous active-high reset
//   instr              : instruction register contents (opcode = instr[30:25])
//   imem_ready         : instruction word available (sampled in FETCH only)
//   dmem_ready         : data access completes (sampled in MEM only)
//   alu_zero           : ALU result is zero (branch compare)
//   imem_req, ir_write : fetch request / latch fetched word
//   pc_write, pc_select: PC load enable / next-PC source
//   imm_extend_select, alu_src2_select, write_reg_select, alu_op : datapath selects
//   reg_write, dmem_read, dmem_write : register-file / data-memory enables
//   illegal            : one-cycle pulse on an undecodable opcode
module cpu_controller #(
    parameter int DataSize = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DataSize-1:0] instr,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_select,
    output logic [1:0]          imm_extend_select,
    output logic [2:0]          alu_src2_select,
    output logic [1:0]          write_reg_select,
    output logic [4:0]          alu_op,
    output logic                reg_write,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic                illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_ADDI, C_ORI, C_MOVI, C_LWI, C_SWI, C_BR, C_J, C_ILL
    } op_class_t;

    state_t    state;
    op_class_t op_class;
    logic [5:0] opcode;
    logic [1:0] dec_ext;
    logic [2:0] dec_src2;
    logic [1:0] dec_wb;
    logic [4:0] dec_alu;
    logic       branch_taken;
    logic       unused_instr_bits;

    assign opcode            = instr[30:25];
    assign unused_instr_bits = ^{instr[DataSize-1:31], instr[24:15], instr[13:10], instr[7:5]};
    // instr[14] selects BNE over BEQ
    assign branch_taken      = alu_zero ^ instr[14];

    // The instruction register only changes in FETCH, so decoding straight
    // from it keeps the selects stable from DECODE to the end of the instruction.
    always_comb begin
        op_class = C_ILL;
        dec_ext  = 2'b00;
        dec_src2 = 3'b000;
        dec_wb   = 2'b00;
        dec_alu  = 5'd0;
        unique case (opcode)
            6'b100000: begin
                op_class = C_ALU;
                dec_alu  = instr[4:0];
                // shift-by-amount form: sub-op 0 with a nonzero shift field
                if (instr[4:0] == 5'b00000 && instr[9:8] != 2'b00)
                    dec_src2 = 3'b011;
            end
            6'b101000: begin op_class = C_ADDI; dec_ext = 2'b01; dec_src2 = 3'b001; end
            6'b101100: begin op_class = C_ORI;  dec_ext = 2'b10; dec_src2 = 3'b001; dec_alu = 5'd3; end
            6'b100010: begin op_class = C_MOVI; dec_ext = 2'b11; dec_src2 = 3'b001; dec_wb = 2'b01; end
            6'b000010: begin op_class = C_LWI;  dec_src2 = 3'b010; dec_wb = 2'b10; end
            6'b001010: begin op_class = C_SWI;  dec_src2 = 3'b010; end
            6'b100110: begin op_class = C_BR;   dec_src2 = 3'b100; dec_alu = 5'd1; end
            6'b100100: op_class = C_J;
            default:   op_class = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:  if (imem_ready) state <= DECODE;
                DECODE: state <= (op_class == C_J || op_class == C_ILL) ? FETCH : EXEC;
                EXEC: begin
                    if (op_class == C_LWI || op_class == C_SWI) state <= MEM;
                    else if (op_class == C_BR)                  state <= FETCH;
                    else                                        state <= WB;
                end
                MEM:    if (dmem_ready) state <= (op_class == C_LWI) ? WB : FETCH;
                WB:     state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are forced low while rst is high so the abort cycle issues no
    // register or memory write regardless of the state being left.
    always_comb begin
        imem_req          = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        pc_select         = 2'b00;
        imm_extend_select = 2'b00;
        alu_src2_select   = 3'b000;
        write_reg_select  = 2'b00;
        alu_op            = 5'd0;
        reg_write         = 1'b0;
        dmem_read         = 1'b0;
        dmem_write        = 1'b0;
        illegal           = 1'b0;
        if (!rst) begin
            if (state != FETCH) begin
                imm_extend_select = dec_ext;
                alu_src2_select   = dec_src2;
                write_reg_select  = dec_wb;
                alu_op            = dec_alu;
            end
            unique case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                DECODE: begin
                    if (op_class == C_J) begin
                        pc_write  = 1'b1;
                        pc_select = 2'b10;
                    end else if (op_class == C_ILL) begin
                        pc_write = 1'b1;
                        illegal  = 1'b1;
                    end
                end
                EXEC: begin
                    if (op_class == C_BR) begin
                        pc_write  = 1'b1;
                        pc_select = branch_taken ? 2'b01 : 2'b00;
                    end
                end
                MEM: begin
                    dmem_read  = (op_class == C_LWI);
                    dmem_write = (op_class == C_SWI);
                    pc_write   = (op_class == C_SWI) && dmem_ready;
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
//   Drives directed and random instruction sequences into cpu_controller and
//   compares every output, every cycle, against a phase-list reference model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, alu_zero;
    logic        imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write, illegal;
    logic [1:0]  pc_select, imm_extend_select, write_reg_select;
    logic [2:0]  alu_src2_select;
    logic [4:0]  alu_op;

    int unsigned checks = 0;
    int unsigned passes = 0;

    cpu_controller #(.DataSize(32)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_select(pc_select), .imm_extend_select(imm_extend_select),
        .alu_src2_select(alu_src2_select), .write_reg_select(write_reg_select),
        .alu_op(alu_op), .reg_write(reg_write), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Instruction kinds as seen by the reference model
    localparam int K_WB = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_J = 4, K_ILL = 5;

    typedef struct {
        int         kind;
        logic [1:0] ext;
        logic [2:0] s2;
        logic [1:0] wb;
        logic [4:0] alu;
    } fields_t;

    // Vector layout: [20]imem_req [19]ir_write [18]pc_write [17:16]pc_select
    // [15:14]ext [13:11]src2 [10:9]wb [8:4]alu_op [3]reg_write [2]dmem_read
    // [1]dmem_write [0]illegal
    function automatic logic [20:0] observed();
        return {imem_req, ir_write, pc_write, pc_select, imm_extend_select,
                alu_src2_select, write_reg_select, alu_op, reg_write,
                dmem_read, dmem_write, illegal};
    endfunction

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    endtask

    function automatic fields_t ref_decode(input logic [31:0] w);
        fields_t f;
        f = '{kind: K_ILL, ext: 2'b00, s2: 3'b000, wb: 2'b00, alu: 5'd0};
        case (w[30:25])
            6'b100000: begin
                f.kind = K_WB; f.alu = w[4:0];
                f.s2 = (w[4:0] == 5'd0 && w[9:8] != 2'd0) ? 3'b011 : 3'b000;
            end
            6'b101000: begin f.kind = K_WB; f.ext = 2'b01; f.s2 = 3'b001; end
            6'b101100: begin f.kind = K_WB; f.ext = 2'b10; f.s2 = 3'b001; f.alu = 5'd3; end
            6'b100010: begin f.kind = K_WB; f.ext = 2'b11; f.s2 = 3'b001; f.wb = 2'b01; end
            6'b000010: begin f.kind = K_LD; f.s2 = 3'b010; f.wb = 2'b10; end
            6'b001010: begin f.kind = K_ST; f.s2 = 3'b010; end
            6'b100110: begin f.kind = K_BR; f.s2 = 3'b100; f.alu = 5'd1; end
            6'b100100: f.kind = K_J;
            default:   f.kind = K_ILL;
        endcase
        return f;
    endfunction

    // Inputs for the current cycle are already applied; check, then advance.
    task automatic cycle(input string tag, input logic [20:0] exp);
        #1;
        check_eq(tag, observed(), exp);
        @(negedge clk);
    endtask

    task automatic noise();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        alu_zero   = 1'($urandom);
    endtask

    // Runs one instruction: fw fetch wait cycles, mw data wait cycles.
    // abort_mem: assert rst in the second MEM cycle instead of completing.
    task automatic run_instr(input string name, input logic [31:0] w, input int fw,
                             input int mw, input logic az, input bit abort_mem);
        fields_t     f;
        logic [20:0] sel, e;
        f = ref_decode(w);
        for (int i = 0; i <= fw; i++) begin
            noise();
            imem_ready = (i == fw);
            e = 21'h100000;
            e[19] = imem_ready;
            cycle($sformatf("%s fetch%0d", name, i), e);
        end
        instr = w;
        sel = {3'b000, 2'b00, f.ext, f.s2, f.wb, f.alu, 4'b0000};
        noise();
        e = sel;
        if (f.kind == K_J)   begin e[18] = 1'b1; e[17:16] = 2'b10; end
        if (f.kind == K_ILL) begin e[18] = 1'b1; e[0] = 1'b1; end
        cycle($sformatf("%s decode", name), e);
        if (f.kind == K_J || f.kind == K_ILL) return;
        noise();
        alu_zero = az;
        e = sel;
        if (f.kind == K_BR) begin
            e[18] = 1'b1;
            // BEQ taken on zero, BNE taken on nonzero
            e[17:16] = ((az == 1'b1) != (w[14] == 1'b1)) ? 2'b01 : 2'b00;
        end
        cycle($sformatf("%s exec", name), e);
        if (f.kind == K_BR) return;
        if (f.kind == K_LD || f.kind == K_ST) begin
            for (int i = 0; i <= mw; i++) begin
                noise();
                dmem_ready = (i == mw);
                if (abort_mem && i == 1) begin
                    rst = 1'b1;
                    dmem_ready = 1'b1;
                    cycle($sformatf("%s rst_in_mem", name), 21'h0);
                    rst = 1'b0;
                    imem_ready = 1'b0;
                    cycle($sformatf("%s after_rst", name), 21'h100000);
                    return;
                end
                e = sel;
                e[2] = (f.kind == K_LD);
                e[1] = (f.kind == K_ST);
                e[18] = (f.kind == K_ST) && dmem_ready;
                cycle($sformatf("%s mem%0d", name, i), e);
            end
            if (f.kind == K_ST) return;
        end
        noise();
        e = sel;
        e[3] = 1'b1;
        e[18] = 1'b1;
        cycle($sformatf("%s wb", name), e);
    endtask

    function automatic logic [31:0] with_op(input logic [5:0] op);
        logic [31:0] w;
        w = $urandom;
        w[30:25] = op;
        return w;
    endfunction

    logic [5:0] legal_ops [8] = '{6'b100000, 6'b101000, 6'b101100, 6'b100010,
                                  6'b000010, 6'b001010, 6'b100110, 6'b100100};

    initial begin
        logic [31:0] w;
        logic [5:0]  op;
        bit          is_legal;
        rst = 1'b1;
        instr = '0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        alu_zero = 1'b0;
        @(negedge clk);
        cycle("reset_hold", 21'h0);
        rst = 1'b0;

        run_instr("addi", with_op(6'b101000), 0, 0, 1'b0, 1'b0);
        run_instr("lwi_wait3", with_op(6'b000010), 0, 3, 1'b0, 1'b0);
        run_instr("swi_wait2", with_op(6'b001010), 2, 2, 1'b0, 1'b0);
        w = with_op(6'b100110); w[14] = 1'b0;
        run_instr("beq_z1", w, 0, 0, 1'b1, 1'b0);
        w[14] = 1'b1;
        run_instr("bne_z1", w, 1, 0, 1'b1, 1'b0);
        run_instr("bne_z0", w, 0, 0, 1'b0, 1'b0);
        run_instr("jump", with_op(6'b100100), 0, 0, 1'b0, 1'b0);
        run_instr("illegal", with_op(6'b111111), 0, 0, 1'b0, 1'b0);
        w = with_op(6'b100000); w[4:0] = 5'd0; w[9:8] = 2'b01;
        run_instr("alu_shift", w, 0, 0, 1'b0, 1'b0);
        w[9:8] = 2'b00;
        run_instr("alu_add", w, 0, 0, 1'b0, 1'b0);
        run_instr("ori", with_op(6'b101100), 0, 0, 1'b0, 1'b0);
        run_instr("movi", with_op(6'b100010), 0, 0, 1'b0, 1'b0);
        run_instr("lwi_abort", with_op(6'b000010), 0, 3, 1'b0, 1'b1);
        run_instr("post_abort", with_op(6'b101000), 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin
                    op = 6'($urandom);
                    is_legal = 1'b0;
                    for (int k = 0; k < 8; k++) if (legal_ops[k] == op) is_legal = 1'b1;
                end while (is_legal);
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            w = with_op(op);
            if (op == 6'b100000 && $urandom_range(0, 2) == 0) w[4:0] = 5'd0;
            run_instr($sformatf("rand%0d", n), w, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
